pc16_stack: RTL

16-bit program counter with an integrated hardware return-address stack, sitting directly downstream of the Inc16 incrementer in the CPU datapath. Each cycle it selects the next fetch address from clear, jump load, subroutine return, subroutine call, increment-by-one or hold, and registers it. It feeds the instruction-memory address bus.

---
 rtl/pc16_stack.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc16_stack.sv
// 16-bit program counter with a LIFO return-address stack.
// Optional macro PC16_SAT_EN: saturating increment with sticky wrap flag.
module pc16_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        inc,
    input  logic        clr,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] out,
    output logic [3:0]  depth,
    output logic        full,
    output logic        empty,
    output logic        err,
    output logic        wrap
);

    localparam logic [3:0] DMAX = 4'(DEPTH);

    logic [15:0] pc_q, pc_d;
    logic [3:0]  depth_q, depth_d;
    logic        err_q, err_d;
    logic [15:0] stack_q [DEPTH];
    logic [15:0] stack_d [DEPTH];

    logic [15:0] ret_addr, top;
    logic        is_full, is_empty, push;
    logic        sel_clr, sel_load, sel_bad, sel_call, sel_ret, sel_inc;

    assign is_full  = (depth_q == DMAX);
    assign is_empty = (depth_q == 4'd0);
    assign ret_addr = pc_q + 16'd1;

    // One-hot action select so the decoder below is truly exclusive.
    assign sel_clr  = clr;
    assign sel_load = !clr && load;
    assign sel_bad  = !clr && !load && call && ret;
    assign sel_call = !clr && !load && call && !ret;
    assign sel_ret  = !clr && !load && ret && !call;
    assign sel_inc  = !clr && !load && !call && !ret && inc;

    always_comb begin
        top = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == 4'(i + 1)) top = stack_q[i];
        end
    end

`ifdef PC16_SAT_EN
    logic wrap_q, wrap_d;
    logic at_max;
    assign at_max = (pc_q == 16'hFFFF);
`endif

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
`ifdef PC16_SAT_EN
        wrap_d  = wrap_q;
`endif
        unique case (1'b1)
            sel_clr: begin
                pc_d    = 16'h0000;
                depth_d = 4'd0;
                err_d   = 1'b0;
`ifdef PC16_SAT_EN
                wrap_d  = 1'b0;
`endif
            end
            sel_load: pc_d = in;
            sel_bad:  err_d = 1'b1;
            sel_call: begin
                pc_d = in;
                if (is_full) begin
                    err_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    depth_d = depth_q + 4'd1;
                end
`ifdef PC16_SAT_EN
                if (at_max) wrap_d = 1'b1;
`endif
            end
            sel_ret: begin
                if (is_empty) begin
                    pc_d  = 16'h0000;
                    err_d = 1'b1;
                end else begin
                    pc_d    = top;
                    depth_d = depth_q - 4'd1;
                end
            end
            sel_inc: begin
`ifdef PC16_SAT_EN
                if (at_max) wrap_d = 1'b1;
                else        pc_d   = ret_addr;
`else
                pc_d = ret_addr;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (push && depth_q == 4'(i)) stack_d[i] = ret_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 16'h0000;
            depth_q <= 4'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

`ifdef PC16_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wrap_q <= 1'b0;
        else        wrap_q <= wrap_d;
    end
    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign out   = pc_q;
    assign depth = depth_q;
    assign full  = is_full;
    assign empty = is_empty;
    assign err   = err_q;

endmodule
